truth_table_sweeper: RTL

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 114 +++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Drives all eight input vectors onto a 3-input gate and records its response as an
// 8-bit truth-table code (vector 000 in the MSB), then compares it with a golden code.
//
// state  | meaning
// IDLE   | waiting for start, vector outputs parked at 000
// DRIVE  | holding vector idx on the gate for SETTLE cycles
// SAMPLE | one cycle: gate response written into table bit (7 - idx)
// DONE   | result valid and frozen until table_ack
module truth_table_sweeper #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] expect_code,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       out,
  output logic       busy,
  output logic       table_valid,
  output logic [7:0] table_code,
  output logic       match,
  input  logic       table_ack
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [3:0] settle_cnt, settle_cnt_n;
  logic [7:0] exp_q, exp_n;
  logic [7:0] table_n, table_upd;
  logic       match_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      settle_cnt <= 4'd0;
      exp_q      <= 8'h00;
      table_code <= 8'h00;
      match      <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      settle_cnt <= settle_cnt_n;
      exp_q      <= exp_n;
      table_code <= table_n;
      match      <= match_n;
    end
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    settle_cnt_n = settle_cnt;
    exp_n        = exp_q;
    table_n      = table_code;
    match_n      = match;
    table_upd    = table_code;
    table_upd[3'd7 - idx] = out;

    case (state)
      IDLE: begin
        if (start) begin
          exp_n        = expect_code;
          table_n      = 8'h00;
          match_n      = 1'b0;
          idx_n        = 3'd0;
          settle_cnt_n = SETTLE_LD;
          state_n      = DRIVE;
        end
      end
      DRIVE: begin
        settle_cnt_n = settle_cnt - 4'd1;
        if (settle_cnt == 4'd1) begin
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        table_n = table_upd;
        if (idx == 3'd7) begin
          // compare against the completed code, including the bit written this cycle
          match_n = (table_upd == exp_q);
          idx_n   = 3'd0;
          state_n = DONE;
        end else begin
          idx_n        = idx + 3'd1;
          settle_cnt_n = SETTLE_LD;
          state_n      = DRIVE;
        end
      end
      DONE: begin
        if (table_ack) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign {in1, in2, in3} = idx;
  assign busy            = (state == DRIVE) || (state == SAMPLE);
  assign table_valid     = (state == DONE);

endmodule
